// File: rtl/mem_stage_sram_ctrl.sv
//==============================================================================
// Module   : mem_stage_sram_ctrl
// Purpose  : Memory-stage controller that serves core loads/stores from an
//            external asynchronous SRAM. Each DATA_W word is split into
//            BEATS = DATA_W/SRAM_DATA_W little-endian beats, each lasting
//            WAIT_CYCLES clocks. While an access is in flight `ready` is low
//            and the core freezes its pipeline on ~ready.
// Ports    : clk, rst             - clock, asynchronous active-high reset
//            rd_en, wr_en         - load / store request (store wins if both)
//            addr, wdata          - core byte address and store data
//            rdata, ready         - load result and pipeline-advance strobe
//            sram_addr            - SRAM word address
//            sram_dq_out/_oe/_in  - SRAM data pad (out, output enable, in)
//            sram_we_n            - SRAM write enable, active low
// Options  : `define SRAM_READ_HIT_EN adds a one-word read buffer that lets a
//            repeated load of the same word complete without an SRAM access.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_stage_sram_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SRAM_DATA_W = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n
);

  localparam int BEATS  = DATA_W / SRAM_DATA_W;
  localparam int OFFS   = $clog2(DATA_W / 8);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(WAIT_CYCLES);

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BEATS_A   = ADDR_W'(BEATS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                 state_q;
  logic [BEAT_W-1:0]      beat_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   op_wr_q;
  logic [ADDR_W-1:0]      word_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic [SRAM_DATA_W-1:0] sram_dq_out_q;
  logic                   sram_dq_oe_q;
  logic                   sram_we_n_q;

  logic                   w_req;
  logic [ADDR_W-1:0]      w_word;
  logic                   w_hit;
  logic [DATA_W-1:0]      w_hit_data;

  assign w_req  = rd_en | wr_en;
  // Modular subtraction: addresses below BASE_ADDR simply wrap.
  assign w_word = (addr - BASE) >> OFFS;

  // SRAM word address of a given beat of a core word.
  function automatic logic [SRAM_ADDR_W-1:0] f_sram_addr(
    input logic [ADDR_W-1:0] word,
    input logic [BEAT_W-1:0] beat
  );
    logic [ADDR_W-1:0] full;
    full = word * BEATS_A + ADDR_W'(beat);
    return full[SRAM_ADDR_W-1:0];
  endfunction

  // Little-endian beat slice of a core word.
  function automatic logic [SRAM_DATA_W-1:0] f_slice(
    input logic [DATA_W-1:0] data,
    input logic [BEAT_W-1:0] beat
  );
    return data[int'(beat)*SRAM_DATA_W +: SRAM_DATA_W];
  endfunction

  //----------------------------------------------------------------------------
  // Access FSM. The SRAM pins are registered; each assignment below sets the
  // pin value for the cycle that the new cnt/beat value describes.
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      cnt_q         <= '0;
      op_wr_q       <= 1'b0;
      word_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_hit) begin
            // Buffered load: finishes this cycle, SRAM stays untouched.
            rdata_q <= w_hit_data;
          end else if (w_req) begin
            state_q       <= S_ACCESS;
            beat_q        <= '0;
            cnt_q         <= '0;
            op_wr_q       <= wr_en;
            word_q        <= w_word;
            wdata_q       <= wdata;
            sram_addr_q   <= f_sram_addr(w_word, '0);
            sram_dq_out_q <= wdata[SRAM_DATA_W-1:0];
            sram_dq_oe_q  <= wr_en;
            // WAIT_CYCLES >= 2, so cnt 0 is never the hold cycle.
            sram_we_n_q   <= ~wr_en;
          end
        end

        S_ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            if (!op_wr_q) begin
              rdata_q[int'(beat_q)*SRAM_DATA_W +: SRAM_DATA_W] <= sram_dq_in;
            end
            if (beat_q != LAST_BEAT) begin
              beat_q        <= beat_q + 1'b1;
              cnt_q         <= '0;
              sram_addr_q   <= f_sram_addr(word_q, beat_q + 1'b1);
              sram_dq_out_q <= f_slice(wdata_q, beat_q + 1'b1);
              sram_we_n_q   <= ~op_wr_q;
            end else begin
              state_q      <= S_DONE;
              sram_dq_oe_q <= 1'b0;
              sram_we_n_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            // Release we_n on the last cycle of a beat so address and data
            // are held stable past the write-enable rising edge.
            sram_we_n_q <= ~op_wr_q | ((cnt_q + 1'b1) == LAST_CNT);
          end
        end

        S_DONE: begin
          // The pipeline advances on this edge; the request still visible
          // here belongs to the finished instruction and is not re-taken.
          state_q <= S_IDLE;
          beat_q  <= '0;
          cnt_q   <= '0;
        end

        default: begin
          state_q      <= S_IDLE;
          sram_dq_oe_q <= 1'b0;
          sram_we_n_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef SRAM_READ_HIT_EN
  logic              hit_vld_q;
  logic [ADDR_W-1:0] hit_tag_q;
  logic [DATA_W-1:0] hit_data_q;

  assign w_hit      = (state_q == S_IDLE) && rd_en && !wr_en &&
                      hit_vld_q && (hit_tag_q == w_word);
  assign w_hit_data = hit_data_q;

  // Read buffer: filled by completed SRAM loads, kept coherent by stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_vld_q  <= 1'b0;
      hit_tag_q  <= '0;
      hit_data_q <= '0;
    end else if (state_q == S_DONE) begin
      if (!op_wr_q) begin
        hit_vld_q  <= 1'b1;
        hit_tag_q  <= word_q;
        hit_data_q <= rdata_q;
      end else if (hit_vld_q && (hit_tag_q == word_q)) begin
        hit_data_q <= wdata_q;
      end
    end
  end

  assign rdata = w_hit ? hit_data_q : rdata_q;
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = rdata_q;
  assign rdata      = rdata_q;
`endif

  assign ready       = ((state_q == S_IDLE) && (!w_req || w_hit)) ||
                       (state_q == S_DONE);
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

endmodule

`default_nettype wire
